// File: rtl/scram_frame_ctrl.sv
// Frame sequencer in front of a parallel scrambler: header words bypass,
// payload words go through Scram. Scram must update Dat_o only on Scr_En.
module scram_frame_ctrl #(
  parameter int DW        = 62,
  parameter int HDR_WORDS = 1,
  parameter int MAX_WORDS = 1024,
  parameter int CW        = 16
) (
  input  logic          Ck,
  input  logic          Rs,
  input  logic          CE,
  input  logic          In_Vld,
  output logic          In_Rdy,
  input  logic [DW-1:0] In_Dat,
  input  logic          In_Sof,
  input  logic          In_Eof,
  output logic          Scr_En,
  output logic [DW-1:0] Scr_Dat,
  input  logic [DW-1:0] Scr_Q,
  output logic          Out_Vld,
  input  logic          Out_Rdy,
  output logic [DW-1:0] Out_Dat,
  output logic          Out_Sof,
  output logic          Out_Eof,
  output logic          Out_Scr,
  output logic [CW-1:0] Frm_Cnt,
  output logic          Err_Len,
  output logic          Err_Frm,
  input  logic          Err_Clr
);

  localparam int NW = $clog2(MAX_WORDS + 1);
  localparam logic [NW-1:0] MAX_C = NW'(MAX_WORDS);
  localparam logic [NW-1:0] HDR_C = NW'(HDR_WORDS);
  localparam logic HAS_HDR = (HDR_WORDS > 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] PAY  = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [NW-1:0] cnt;
  logic [NW-1:0] cnt_n;
  logic [DW-1:0] byp;
  logic          accept;
  logic          in_frame;
  logic          start;
  logic          emit;
  logic          is_hdr;
  logic          len_hit;
  logic          frm_err;

  assign In_Rdy   = CE & (~Out_Vld | Out_Rdy);
  assign accept   = In_Vld & In_Rdy;
  assign in_frame = (state == HDR) | (state == PAY);

  // SOF opens a new frame from any state except DROP
  assign start   = In_Sof & (state != DROP);
  assign emit    = accept & (start | in_frame);
  assign cnt_n   = start ? NW'(1) : cnt + 1'b1;
  assign is_hdr  = start ? HAS_HDR : (state == HDR);
  assign len_hit = emit & (cnt_n == MAX_C) & ~In_Eof;
  assign frm_err = accept &
                   (((state == IDLE) & ~In_Sof) |
                    (in_frame & In_Sof));

  assign Scr_En  = emit & ~is_hdr;
  assign Scr_Dat = In_Dat;
  assign Out_Dat = Out_Scr ? Scr_Q : byp;

  always_comb begin
    state_n = state;
    if (emit) begin
      if (In_Eof)
        state_n = IDLE;
      else if (len_hit)
        state_n = DROP;
      else if (is_hdr && (cnt_n < HDR_C))
        state_n = HDR;
      else
        state_n = PAY;
    end else if (accept && (state == DROP) && In_Eof) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge Ck or posedge Rs) begin
    if (Rs) begin
      state   <= IDLE;
      cnt     <= '0;
      byp     <= '0;
      Out_Vld <= 1'b0;
      Out_Sof <= 1'b0;
      Out_Eof <= 1'b0;
      Out_Scr <= 1'b0;
      Frm_Cnt <= '0;
      Err_Len <= 1'b0;
      Err_Frm <= 1'b0;
    end else if (CE) begin
      state <= state_n;
      if (emit) begin
        cnt     <= cnt_n;
        Out_Vld <= 1'b1;
        Out_Sof <= start;
        Out_Eof <= In_Eof | len_hit;
        Out_Scr <= ~is_hdr;
      end else if (Out_Rdy) begin
        Out_Vld <= 1'b0;
      end
      if (emit && is_hdr)
        byp <= In_Dat;
      if (Out_Vld && Out_Rdy && Out_Eof)
        Frm_Cnt <= Frm_Cnt + 1'b1;
      // a new error outranks a clear in the same cycle
      if (len_hit)
        Err_Len <= 1'b1;
      else if (Err_Clr)
        Err_Len <= 1'b0;
      if (frm_err)
        Err_Frm <= 1'b1;
      else if (Err_Clr)
        Err_Frm <= 1'b0;
    end
  end

endmodule
